storage_wb_bridge: RTL and testbench

Wishbone B4 classic slave that fronts the management SRAM macro array. It decodes a byte-addressed window of `RAM_BLOCKS` x 1 KB, sequences each access into the SRAM read/write port, and returns registered read data and a one-cycle acknowledge. It sits directly upstream of `storage` and drives its R/W chip-select, write-enable, mask, address and data ports. It consumes the concatenated read-data bus that `storage` returns.

---
 rtl/storage_wb_bridge.sv | 104 ++++++++++
 tb/tb_storage_wb_bridge.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/storage_wb_bridge.sv
// storage_wb_bridge: Wishbone B4 classic slave in front of the management SRAM array.
// One access in flight: IDLE -> ACCESS -> (RDWAIT) -> ACK; misses ack straight from IDLE.
module storage_wb_bridge #(
  parameter int          RAM_BLOCKS = 2,
  parameter logic [31:0] BASE_ADR   = 32'h0000_0000
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic                      wb_cyc_i,
  input  logic                      wb_stb_i,
  input  logic                      wb_we_i,
  input  logic [3:0]                wb_sel_i,
  input  logic [31:0]               wb_adr_i,
  input  logic [31:0]               wb_dat_i,
  output logic                      wb_ack_o,
  output logic [31:0]               wb_dat_o,
  output logic [RAM_BLOCKS-1:0]     mgmt_ena,
  output logic [RAM_BLOCKS-1:0]     mgmt_wen,
  output logic [RAM_BLOCKS*4-1:0]   mgmt_wen_mask,
  output logic [7:0]                mgmt_addr,
  output logic [31:0]               mgmt_wdata,
  input  logic [RAM_BLOCKS*32-1:0]  mgmt_rdata
);
  localparam int BW = (RAM_BLOCKS > 1) ? $clog2(RAM_BLOCKS) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT, ACK} state_t;
  typedef struct packed {
    logic          we;
    logic [BW-1:0] blk;
  } req_t;

  state_t                  state, state_nx;
  req_t                    req_q;
  logic [31:0]             off;
  logic                    hit, start;
  logic [BW-1:0]           blk;
  logic [RAM_BLOCKS-1:0]   ena_nx, wen_nx;
  logic [RAM_BLOCKS*4-1:0] mask_nx;
  logic                    unused_off;

  assign off        = wb_adr_i - BASE_ADR;
  assign hit        = off[31:10] < 22'(RAM_BLOCKS);
  assign blk        = off[10 +: BW];
  assign start      = (state == IDLE) && wb_cyc_i && wb_stb_i;
  assign unused_off = &{1'b0, off[1:0]};

  // Per-block strobe decode; only the hit block ever sees a low enable or a mask.
  for (genvar b = 0; b < RAM_BLOCKS; b++) begin : g_lane
    logic sel_b;
    assign sel_b                = hit && (blk == BW'(b));
    assign ena_nx[b]            = ~sel_b;
    assign wen_nx[b]            = ~(sel_b && wb_we_i);
    assign mask_nx[4*b +: 4]    = (sel_b && wb_we_i) ? wb_sel_i : 4'h0;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (wb_cyc_i && wb_stb_i) state_nx = hit ? ACCESS : ACK;
      ACCESS:  state_nx = req_q.we ? ACK : RDWAIT;
      RDWAIT:  state_nx = ACK;
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Strobes are asserted for exactly the ACCESS cycle: loaded on accept, released on the next edge.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      mgmt_ena      <= '1;
      mgmt_wen      <= '1;
      mgmt_wen_mask <= '0;
      mgmt_addr     <= '0;
      mgmt_wdata    <= '0;
      wb_dat_o      <= '0;
      req_q         <= '0;
    end else begin
      mgmt_ena      <= '1;
      mgmt_wen      <= '1;
      mgmt_wen_mask <= '0;
      if (start) begin
        if (hit) begin
          mgmt_ena      <= ena_nx;
          mgmt_wen      <= wen_nx;
          mgmt_wen_mask <= mask_nx;
          mgmt_addr     <= off[9:2];
          mgmt_wdata    <= wb_dat_i;
          req_q         <= '{we: wb_we_i, blk: blk};
        end else begin
          wb_dat_o <= '0;
        end
      end
      if (state == RDWAIT) wb_dat_o <= mgmt_rdata[32*req_q.blk +: 32];
    end
  end

  assign wb_ack_o = (state == ACK);

endmodule

// File: tb/tb_storage_wb_bridge.sv
// Bench for storage_wb_bridge: directed table, back-to-back and reset sequences,
// then random traffic against a word-level memory model.
module tb_storage_wb_bridge;
  localparam int          RB   = 2;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic clk = 1'b0;
  logic rst, cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        ack;
  logic [31:0] dato;
  logic [RB-1:0]    ena, wen;
  logic [RB*4-1:0]  mask;
  logic [7:0]       maddr;
  logic [31:0]      mwdata;
  logic [RB*32-1:0] mrdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  storage_wb_bridge #(.RAM_BLOCKS(RB), .BASE_ADR(BASE)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_sel_i(sel), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_ack_o(ack), .wb_dat_o(dato),
    .mgmt_ena(ena), .mgmt_wen(wen), .mgmt_wen_mask(mask), .mgmt_addr(maddr),
    .mgmt_wdata(mwdata), .mgmt_rdata(mrdata)
  );

  // SRAM macro model: samples its port at the clock edge, read data one cycle later.
  bit [31:0] smem [RB][256];
  bit [31:0] srd  [RB];
  always @(posedge clk) begin
    for (int b = 0; b < RB; b++) begin
      if (!ena[b]) begin
        if (!wen[b]) begin
          for (int k = 0; k < 4; k++)
            if (mask[4*b+k]) smem[b][maddr][8*k +: 8] <= mwdata[8*k +: 8];
        end else begin
          srd[b] <= smem[b][maddr];
        end
      end
    end
  end
  for (genvar b = 0; b < RB; b++) begin : g_rd
    assign mrdata[32*b +: 32] = srd[b];
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
    end
  endtask

  // Port-level invariants, every cycle.
  always @(negedge clk) begin
    logic ok;
    ok = ($countones(~ena) <= 1);
    for (int b = 0; b < RB; b++) begin
      if (!wen[b] && ena[b]) ok = 1'b0;
      if ((mask[4*b +: 4] != 4'h0) && wen[b]) ok = 1'b0;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL port_invariant ena=%b wen=%b mask=%h required one-hot-low strobe", ena, wen, mask);
    end
  end

  // Reference model: word-addressed memory plus the last read/miss data returned.
  logic [31:0] ref_mem [int];
  logic [31:0] ref_dato = '0;

  task automatic ref_apply(input logic w, input logic [31:0] a, input logic [3:0] s,
                           input logic [31:0] d, output int lat);
    logic [31:0] o, cur;
    int key;
    o = a - BASE;
    if (o >= 32'(RB*1024)) begin
      lat = 1;
      ref_dato = '0;
      return;
    end
    key = int'(o / 4);
    cur = ref_mem.exists(key) ? ref_mem[key] : 32'h0;
    if (w) begin
      for (int k = 0; k < 4; k++) if (s[k]) cur[8*k +: 8] = d[8*k +: 8];
      ref_mem[key] = cur;
      lat = 2;
    end else begin
      ref_dato = cur;
      lat = 3;
    end
  endtask

  typedef struct {
    int              lat;
    logic [31:0]     rd;
    int              nlow;
    logic [RB-1:0]   ena;
    logic [RB-1:0]   wen;
    logic [RB*4-1:0] mask;
    logic [7:0]      addr;
    logic [31:0]     wd;
  } obs_t;

  task automatic txn(input logic w, input logic [31:0] a, input logic [3:0] s,
                     input logic [31:0] d, output obs_t ob);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; wdat = d;
    ob.lat = 0; ob.rd = '0; ob.nlow = 0; ob.ena = '1; ob.wen = '1;
    ob.mask = '0; ob.addr = '0; ob.wd = '0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); @(negedge clk);
      if (ena != '1) begin
        ob.nlow++; ob.ena = ena; ob.wen = wen; ob.mask = mask; ob.addr = maddr; ob.wd = mwdata;
      end
      if (ack) begin
        ob.lat = n; ob.rd = dato;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    if (ob.lat == 0) begin
      total++; bad++;
      $display("FAIL txn_timeout adr=%h no ack within 20 cycles", a);
    end
    @(posedge clk); #1;
  endtask

  task automatic run(input logic w, input logic [31:0] a, input logic [3:0] s,
                     input logic [31:0] d, output obs_t ob);
    int elat, bi;
    logic [31:0] o;
    logic [RB-1:0] eb;
    logic [RB*4-1:0] em;
    o = a - BASE;
    ref_apply(w, a, s, d, elat);
    txn(w, a, s, d, ob);
    chk("latency", 64'(ob.lat), 64'(elat));
    chk("wb_dat_o", ob.rd, ref_dato);
    if (o < 32'(RB*1024)) begin
      bi = int'(o / 1024);
      eb = '1; eb[bi] = 1'b0;
      em = '0; if (w) em[bi*4 +: 4] = s;
      chk("strobe_cycles", 64'(ob.nlow), 64'd1);
      chk("mgmt_ena", ob.ena, eb);
      chk("mgmt_wen", ob.wen, w ? eb : {RB{1'b1}});
      chk("mgmt_wen_mask", ob.mask, em);
      chk("mgmt_addr", ob.addr, o[9:2]);
      if (w) chk("mgmt_wdata", ob.wd, d);
    end else begin
      chk("miss_strobe_cycles", 64'(ob.nlow), 64'd0);
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_ack"}, ack, 1'b0);
    chk({nm, "_dat"}, dato, 32'h0);
    chk({nm, "_ena"}, ena, 2'b11);
    chk({nm, "_wen"}, wen, 2'b11);
    chk({nm, "_mask"}, mask, 8'h00);
    chk({nm, "_addr"}, maddr, 8'h00);
    chk({nm, "_wdata"}, mwdata, 32'h0);
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [3:0]  s;
    logic [31:0] d;
    int          lat;
    logic [31:0] rd;
    logic [1:0]  ena;
    logic [1:0]  wen;
    logic [7:0]  mask;
    logic [7:0]  addr;
  } vec_t;

  vec_t tv [8];

  initial begin
    obs_t ob;
    int nack, lat_dummy;
    int ackpos [3];
    logic [31:0] ackdat [3];
    logic [31:0] r1, r3, o;

    tv[0] = '{1'b1, BASE + 32'h404, 4'hF, 32'hCAFE_F00D, 2, 32'h0,         2'b01, 2'b01, 8'hF0, 8'h01};
    tv[1] = '{1'b0, BASE + 32'h404, 4'hF, 32'h0,         3, 32'hCAFE_F00D, 2'b01, 2'b11, 8'h00, 8'h01};
    tv[2] = '{1'b1, BASE + 32'h000, 4'hF, 32'h1111_1111, 2, 32'hCAFE_F00D, 2'b10, 2'b10, 8'h0F, 8'h00};
    tv[3] = '{1'b1, BASE + 32'h000, 4'h2, 32'h0000_AB00, 2, 32'hCAFE_F00D, 2'b10, 2'b10, 8'h02, 8'h00};
    tv[4] = '{1'b0, BASE + 32'h000, 4'hF, 32'h0,         3, 32'h1111_AB11, 2'b10, 2'b11, 8'h00, 8'h00};
    tv[5] = '{1'b0, BASE + 32'h800, 4'hF, 32'h0,         1, 32'h0,         2'b11, 2'b11, 8'h00, 8'h00};
    tv[6] = '{1'b1, BASE - 32'h4,   4'hF, 32'hDEAD_BEEF, 1, 32'h0,         2'b11, 2'b11, 8'h00, 8'h00};
    tv[7] = '{1'b0, BASE + 32'h407, 4'hF, 32'h0,         3, 32'hCAFE_F00D, 2'b01, 2'b11, 8'h00, 8'h01};

    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0; adr = '0; wdat = '0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk_reset_vals("por");
    @(posedge clk); #1 rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run(tv[i].w, tv[i].a, tv[i].s, tv[i].d, ob);
      chk($sformatf("tv%0d_lat", i), 64'(ob.lat), 64'(tv[i].lat));
      chk($sformatf("tv%0d_rd", i), ob.rd, tv[i].rd);
      if (tv[i].ena != 2'b11) begin
        chk($sformatf("tv%0d_ena", i), ob.ena, tv[i].ena);
        chk($sformatf("tv%0d_wen", i), ob.wen, tv[i].wen);
        chk($sformatf("tv%0d_mask", i), ob.mask, tv[i].mask);
        chk($sformatf("tv%0d_addr", i), ob.addr, tv[i].addr);
      end else begin
        chk($sformatf("tv%0d_nostrobe", i), 64'(ob.nlow), 64'd0);
      end
    end

    // Strobe held across read, write, read.
    ref_apply(1'b0, BASE + 32'h404, 4'hF, 32'h0, lat_dummy); r1 = ref_dato;
    ref_apply(1'b1, BASE + 32'h404, 4'hF, 32'h1234_5678, lat_dummy);
    ref_apply(1'b0, BASE + 32'h404, 4'hF, 32'h0, lat_dummy); r3 = ref_dato;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h404; sel = 4'hF; wdat = '0;
    nack = 0;
    for (int i = 0; i < 3; i++) begin ackpos[i] = -1; ackdat[i] = '0; end
    for (int e = 0; e < 14; e++) begin
      @(posedge clk); @(negedge clk);
      if (ack) begin
        if (nack < 3) begin ackpos[nack] = e; ackdat[nack] = dato; end
        nack++;
        if (nack == 1)      begin we = 1'b1; wdat = 32'h1234_5678; end
        else if (nack == 2) begin we = 1'b0; end
        else                begin stb = 1'b0; cyc = 1'b0; end
      end
    end
    chk("b2b_acks", 64'(nack), 64'd3);
    chk("b2b_ack0_pos", 64'(ackpos[0]), 64'd2);
    chk("b2b_ack1_pos", 64'(ackpos[1]), 64'd5);
    chk("b2b_ack2_pos", 64'(ackpos[2]), 64'd9);
    chk("b2b_rd0", ackdat[0], r1);
    chk("b2b_wr_hold", ackdat[1], r1);
    chk("b2b_rd2", ackdat[2], r3);

    // Reset while the read sits in RDWAIT.
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h404;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0;
    @(posedge clk); @(negedge clk);
    chk_reset_vals("rst_rdwait");
    @(posedge clk); #1 rst = 1'b0;
    nack = 0;
    for (int e = 0; e < 4; e++) begin
      @(posedge clk); @(negedge clk);
      if (ack) nack++;
    end
    chk("rst_rdwait_noack", 64'(nack), 64'd0);
    chk("rst_rdwait_dat", dato, 32'h0);
    ref_dato = '0;

    // Reset in ACCESS: the write already on the SRAM port lands, no ack follows.
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'h000; sel = 4'hF; wdat = 32'hAAAA_5555;
    @(posedge clk); #1;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    ref_apply(1'b1, BASE + 32'h000, 4'hF, 32'hAAAA_5555, lat_dummy);
    nack = 0;
    @(posedge clk); @(negedge clk);
    if (ack) nack++;
    chk("rst_access_ena", ena, 2'b11);
    @(posedge clk); #1 rst = 1'b0;
    for (int e = 0; e < 3; e++) begin
      @(posedge clk); @(negedge clk);
      if (ack) nack++;
    end
    chk("rst_access_noack", 64'(nack), 64'd0);
    chk("rst_access_dat", dato, 32'h0);
    ref_dato = '0;
    run(1'b0, BASE + 32'h000, 4'hF, 32'h0, ob);
    chk("rst_access_landed", ob.rd, 32'hAAAA_5555);

    // Random traffic, biased toward a small address pool for read-after-write hits.
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 7))
        0, 1, 2, 3: o = 32'($urandom_range(0, RB-1) * 1024 + $urandom_range(0, 7) * 4 + $urandom_range(0, 3));
        4, 5:       o = 32'($urandom_range(0, RB*1024 - 1));
        6:          o = 32'(RB*1024 + $urandom_range(0, 4095));
        default:    o = 32'h0 - 32'($urandom_range(1, 4096));
      endcase
      run(1'($urandom_range(0, 1)), BASE + o, 4'($urandom_range(0, 15)), $urandom, ob);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
